// File: rtl/spi_master_if.sv
// Controller-side handshake bundle for spi_master.
// The controller drives start/hold_ss/din; the SPI master answers with busy/done/dout.
interface spi_master_if;
  logic       start;
  logic       hold_ss;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;

  // Controller (initiator of byte requests)
  modport master (
    output start,
    output hold_ss,
    output din,
    input  dout,
    input  busy,
    input  done
  );

  // SPI master engine (serves byte requests)
  modport slave (
    input  start,
    input  hold_ss,
    input  din,
    output dout,
    output busy,
    output done
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One byte per accepted start; the received byte comes back with a one-cycle done pulse.
// hold_ss=1 keeps ss low after the byte so the next start continues a burst.
// Every output is a flop, so all pins change exactly on clk rising edges.
module spi_master #(
  parameter int CLK_DIV = 4  // sck half-period in clk cycles, must be >= 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  ctrl,
  output logic         ss,
  output logic         sck,
  output logic         mosi,
  input  logic         miso
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          bit_last_q, bit_last_d;
  logic [7:0]    shift_tx_q, shift_tx_d;
  logic [7:0]    shift_rx_q, shift_rx_d;
  logic          hold_r_q, hold_r_d;
  logic          ss_q, ss_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    dout_q, dout_d;

  logic          phase_end;

  // Last clk cycle of the current CLK_DIV-long phase.
  assign phase_end = (div_q == DIV_LAST);

  // Next-state, datapath and registered-output decode for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = phase_end ? '0 : div_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    bit_last_d = bit_last_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    hold_r_d   = hold_r_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    dout_d     = dout_q;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        // busy_q is still high in the done cycle of a burst byte, which is
        // what makes a start coincident with done get ignored.
        if (ctrl.start && !busy_q) begin
          shift_tx_d = ctrl.din;
          hold_r_d   = ctrl.hold_ss;
          bit_cnt_d  = 3'd0;
          bit_last_d = 1'b0;
          ss_d       = 1'b0;
          mosi_d     = ctrl.din[7];
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        // miso is sampled raw on the first cycle of the high phase; the slave
        // has had a full low phase to settle it.
        if (div_q == '0) begin
          shift_rx_d = {shift_rx_q[6:0], miso};
          if (bit_cnt_q == 3'd7) begin
            bit_last_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        if (phase_end) begin
          sck_d = 1'b0;
          // After the 8th rising edge the trailing low phase is the HOLD
          // phase itself, so done lands CLK_DIV cycles after the last fall.
          if (bit_last_q) begin
            state_d = ST_HOLD;
          end else begin
            shift_tx_d = {shift_tx_q[6:0], 1'b0};
            mosi_d     = shift_tx_q[6];
            state_d    = ST_LOW;
          end
        end
      end

      ST_LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HOLD: begin
        if (phase_end) begin
          done_d = 1'b1;
          dout_d = shift_rx_q;
          ss_d   = !hold_r_q;
          state_d = hold_r_q ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // mosi only carries data while the slave is selected.
    if (ss_d) begin
      mosi_d = 1'b0;
    end

    // busy covers the done cycle too, so a burst byte reports busy low one
    // cycle after its done pulse.
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // State and output registers with synchronous reset; a reset mid-transfer
  // simply drops the partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_cnt_q  <= 3'd0;
      bit_last_q <= 1'b0;
      shift_tx_q <= 8'h00;
      shift_rx_q <= 8'h00;
      hold_r_q   <= 1'b0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_last_q <= bit_last_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      hold_r_q   <= hold_r_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
    end
  end

  assign ss        = ss_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign ctrl.busy = busy_q;
  assign ctrl.done = done_q;
  assign ctrl.dout = dout_q;

endmodule
